// File: rtl/stmt_pkg.sv
// Shared types and constants for the statement arbiter.
// State encoding and the ASCII bytes the arbiter reacts to.
package stmt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_WAIT,
    S_REPORT
  } state_e;

  localparam logic [7:0] ASCII_SEMI = 8'h3B;
  localparam logic [7:0] ASCII_NUL  = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first set request bit at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the far end so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stmt_arbiter.sv
// Shares one declaration checker between N character sources,
// one whole ';'-terminated statement per grant.
module stmt_arbiter
  import stmt_pkg::*;
#(
  parameter int N       = 2,
  parameter int MAX_LEN = 32,
  parameter int CHK_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         res_valid,
  output logic                 res_ok,
  output logic                 res_abort,
  output logic                 chk_reset,
  output logic [7:0]           chk_in,
  input  logic                 chk_out,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int LW = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LW-1:0] lat_q, lat_d;
  logic          ok_q, ok_d;
  logic          abort_q, abort_d;
  logic [7:0]    chk_in_q, chk_in_d;
  logic          chk_reset_q, chk_reset_d;
  logic          busy_q;
  logic          cur_valid;
  logic [7:0]    cur_byte;

  rr_pick #(
    .N (N),
    .IW(IW)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign cur_valid = req_valid[grant_q];
  assign cur_byte  = req_data[{grant_q, 3'b000} +: 8];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    ok_d        = ok_q;
    abort_d     = abort_q;
    chk_in_d    = ASCII_NUL;
    chk_reset_d = 1'b0;
    req_ready   = '0;
    res_valid   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          state_d     = S_CLR;
          chk_reset_d = 1'b1;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        ok_d    = 1'b0;
        abort_d = 1'b0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        req_ready[grant_q] = 1'b1;
        // A gap in the stream voids the statement.
        if (!cur_valid) begin
          ok_d        = 1'b0;
          abort_d     = 1'b1;
          chk_reset_d = 1'b1;
          state_d     = S_REPORT;
        end else begin
          chk_in_d = cur_byte;
          cnt_d    = cnt_inc;
          if (cur_byte == ASCII_SEMI) begin
            lat_d   = '0;
            state_d = S_WAIT;
          end else if (cnt_inc == CW'(MAX_LEN)) begin
            ok_d        = 1'b0;
            abort_d     = 1'b1;
            chk_reset_d = 1'b1;
            state_d     = S_REPORT;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == LW'(CHK_LAT)) begin
          ok_d    = chk_out;
          state_d = S_REPORT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_REPORT: begin
        res_valid[grant_q] = 1'b1;
        if (int'(grant_q) == N - 1) begin
          rr_d = '0;
        end else begin
          rr_d = grant_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      ok_q        <= 1'b0;
      abort_q     <= 1'b0;
      chk_in_q    <= ASCII_NUL;
      chk_reset_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      ok_q        <= ok_d;
      abort_q     <= abort_d;
      chk_in_q    <= chk_in_d;
      chk_reset_q <= chk_reset_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign res_ok    = (state_q == S_REPORT) & ok_q;
  assign res_abort = (state_q == S_REPORT) & abort_q;
  assign chk_in    = chk_in_q;
  assign chk_reset = chk_reset_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_stmt_arbiter.sv
// Scoreboard bench for stmt_arbiter with a string-level
// declaration checker and per-lane expected-response queues.
module tb_stmt_arbiter;

  localparam int N    = 2;
  localparam int MAXL = 10;
  localparam int LAT  = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [15:0]  req_data = '0;
  logic [1:0]   req_ready;
  logic [1:0]   res_valid;
  logic         res_ok;
  logic         res_abort;
  logic         chk_reset;
  logic [7:0]   chk_in;
  logic         chk_out = 1'b0;
  logic         busy;
  logic [0:0]   grant_id;

  stmt_arbiter #(
    .N      (N),
    .MAX_LEN(MAXL),
    .CHK_LAT(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ok   (res_ok),
    .res_abort(res_abort),
    .chk_reset(chk_reset),
    .chk_in   (chk_in),
    .chk_out  (chk_out),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string s;
    int    gap;
    int    idle;
  } stim_t;

  typedef struct {
    bit ok;
    bit ab;
    int nacc;
  } exp_t;

  stim_t sq0[$];
  stim_t sq1[$];
  exp_t  eq0[$];
  exp_t  eq1[$];
  int    errors = 0;
  int    checks = 0;
  bit    drv_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic string ch(input logic [7:0] c);
    string t;
    t = " ";
    t.putc(0, c);
    return t;
  endfunction

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A)
        || c == 8'h5F;
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // "<type> id[,id]*;" with type in {int,char,long}
  function automatic bit valid_decl(input string s);
    int n, p;
    bit want_start;
    logic [7:0] c;
    string ty;
    n = s.len();
    if (n == 0) return 1'b0;
    c = s[n-1];
    if (c != 8'h3B) return 1'b0;
    p = -1;
    for (int i = 0; i < n; i++) begin
      c = s[i];
      if (p < 0 && c == 8'h20) p = i;
    end
    if (p < 1) return 1'b0;
    ty = s.substr(0, p - 1);
    if (ty != "int" && ty != "char" && ty != "long") return 1'b0;
    want_start = 1'b1;
    for (int i = p + 1; i < n - 1; i++) begin
      c = s[i];
      if (want_start) begin
        if (!is_alpha(c)) return 1'b0;
        want_start = 1'b0;
      end else if (c == 8'h2C) begin
        want_start = 1'b1;
      end else if (!is_alpha(c) && !is_digit(c)) begin
        return 1'b0;
      end
    end
    return !want_start;
  endfunction

  function automatic exp_t exp_of(input stim_t st);
    exp_t e;
    int n;
    n = st.s.len();
    if (n > MAXL && (st.gap < 0 || st.gap >= MAXL)) begin
      e.ok = 1'b0; e.ab = 1'b1; e.nacc = MAXL;
    end else if (st.gap >= 0) begin
      e.ok = 1'b0; e.ab = 1'b1; e.nacc = st.gap;
    end else begin
      e.ok = valid_decl(st.s); e.ab = 1'b0; e.nacc = n;
    end
    return e;
  endfunction

  function automatic string rand_stmt();
    string s;
    int t, n, len, r;
    logic [7:0] c;
    t = $urandom_range(0, 9);
    s = (t < 4) ? "int" : (t < 7) ? "char" : (t < 9) ? "long" : "itn";
    s = {s, " "};
    n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) begin
      if (i > 0) s = {s, ","};
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 19);
        if (r == 0) c = 8'hC3;
        else if (r < 3) c = 8'h30 + 8'($urandom_range(0, 9));
        else if (r == 3) c = 8'h5F;
        else c = 8'h61 + 8'($urandom_range(0, 25));
        s = {s, ch(c)};
      end
    end
    return {s, ";"};
  endfunction

  // Reference checker: buffers the statement, verdict one cycle after ';'
  string cbuf = "";
  always @(posedge clk) begin
    if (chk_reset === 1'b1) begin
      cbuf = "";
    end else if (chk_in !== 8'h00 && !$isunknown(chk_in)) begin
      cbuf = {cbuf, " "};
      cbuf.putc(cbuf.len() - 1, chk_in);
    end
    chk_out <= (cbuf.len() > 0 && cbuf[cbuf.len()-1] == 8'h3B)
               ? valid_decl(cbuf) : 1'b0;
  end

  // Requester lanes
  int    idx[2];
  int    wt[2];
  bit    act[2];
  stim_t cur[2];

  initial begin
    logic [1:0] acc, rv;
    logic ab;
    stim_t st;
    bit got;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      rv  = res_valid;
      ab  = res_abort;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int i = 0; i < 2; i++) begin
          if (act[i]) begin
            if (acc[i]) idx[i]++;
            if ((rv[i] && ab) || idx[i] >= cur[i].s.len()) act[i] = 1'b0;
          end
          if (!act[i]) begin
            got = 1'b0;
            if (i == 0 && sq0.size() > 0) begin st = sq0.pop_front(); got = 1'b1; end
            if (i == 1 && sq1.size() > 0) begin st = sq1.pop_front(); got = 1'b1; end
            if (got) begin
              cur[i] = st;
              act[i] = 1'b1;
              idx[i] = 0;
              wt[i]  = st.idle;
              if (i == 0) eq0.push_back(exp_of(st));
              else eq1.push_back(exp_of(st));
            end
          end
          if (act[i] && wt[i] == 0 && !(cur[i].gap >= 0 && idx[i] >= cur[i].gap)) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = cur[i].s[idx[i]];
          end else begin
            req_valid[i] = 1'b0;
            if (act[i] && wt[i] > 0) wt[i]--;
          end
        end
      end
    end
  end

  // Monitor
  int         cyc = 0;
  int         grant_cyc = 0;
  int         semi_cyc = 0;
  int         nacc = 0;
  int         rr_m = 0;
  bit         prev_busy = 1'b0;
  bit         seen_ready = 1'b0;
  bit         fwd_pend = 1'b0;
  logic [1:0] prev_valid = '0;
  logic [7:0] fwd_byte = '0;

  always @(negedge clk) begin
    exp_t e;
    int g, ln;
    cyc++;
    if (reset) begin
      rr_m = 0; prev_busy = 1'b0; prev_valid = '0; fwd_pend = 1'b0;
    end else begin
      if (fwd_pend) chk("chk_in_fwd", chk_in, fwd_byte);
      fwd_pend = 1'b0;
      if (!prev_busy && prev_valid != 0) begin
        g = prev_valid[rr_m] ? rr_m : 1 - rr_m;
        chk("grant_start", busy, 1);
        chk("grant_id", grant_id, g);
        chk("clr_reset", chk_reset, 1);
        chk("clr_chk_in", chk_in, 0);
        grant_cyc = cyc; seen_ready = 1'b0; nacc = 0; semi_cyc = -100;
      end
      if (req_ready != 0) begin
        chk("ready_lane", req_ready, 2'b01 << grant_id);
        if (!seen_ready) begin
          chk("first_ready", cyc, grant_cyc + 1);
          seen_ready = 1'b1;
        end
        ln = int'(grant_id);
        if (req_valid[ln]) begin
          nacc++;
          fwd_pend = 1'b1;
          fwd_byte = req_data[8*ln +: 8];
          if (fwd_byte == 8'h3B) semi_cyc = cyc;
        end
      end
      if (res_valid != 0) begin
        chk("res_onehot", $countones(res_valid), 1);
        ln = int'(grant_id);
        chk("res_lane", res_valid[ln], 1);
        chk("res_pending", (ln == 0 ? eq0.size() : eq1.size()) > 0, 1);
        if ((ln == 0 ? eq0.size() : eq1.size()) > 0) begin
          e = (ln == 0) ? eq0.pop_front() : eq1.pop_front();
          chk("res_ok", res_ok, e.ok);
          chk("res_abort", res_abort, e.ab);
          chk("res_nacc", nacc, e.nacc);
          if (e.ab) chk("abort_clr", chk_reset, 1);
          else chk("res_latency", cyc, semi_cyc + 3);
        end
        rr_m = (ln + 1) % 2;
      end
      prev_busy  = busy;
      prev_valid = req_valid;
    end
  end

  task automatic push(input int lane, input string s, input int gap,
                      input int idle);
    stim_t st;
    st.s = s; st.gap = gap; st.idle = idle;
    if (lane == 0) sq0.push_back(st);
    else sq1.push_back(st);
  endtask

  task automatic wait_quiet(input int budget);
    int c;
    c = 0;
    while (c < budget && !(sq0.size() == 0 && sq1.size() == 0 && !act[0]
           && !act[1] && eq0.size() == 0 && eq1.size() == 0 && !busy)) begin
      @(negedge clk);
      #2;
      c++;
    end
    if (c >= budget) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: waited %0d cycles", c);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ok", res_ok, 0);
    chk("rst_res_abort", res_abort, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_chk_in", chk_in, 0);
    chk("rst_chk_reset", chk_reset, 1);
  endtask

  initial begin
    string rs;
    int k, to, nres, lane;
    stim_t st;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    drv_en = 1'b1;

    push(0, "int a,b;", -1, 0);
    wait_quiet(200);
    push(1, "int 0,a7b;", -1, 0);
    wait_quiet(200);
    push(0, "char x;", -1, 0);
    push(1, "long yy,z;", -1, 0);
    wait_quiet(200);
    push(0, "int q;", -1, 0);
    push(1, "int 9;", -1, 0);
    wait_quiet(200);
    push(0, "int a;", 2, 0);
    push(0, "int b;", -1, 0);
    wait_quiet(200);
    push(0, "int abcdefg;", -1, 0);
    push(0, "int ab,cd;", -1, 0);
    wait_quiet(200);
    push(1, {"int ", ch(8'hC3), ";"}, -1, 0);
    push(1, "long e;", -1, 0);
    wait_quiet(200);

    for (int i = 0; i < 80; i++) begin
      st.s    = rand_stmt();
      st.gap  = ($urandom_range(0, 6) == 0)
                ? int'($urandom_range(1, st.s.len() - 1)) : -1;
      st.idle = $urandom_range(0, 3);
      lane    = $urandom_range(0, 1);
      push(lane, st.s, st.gap, st.idle);
    end
    wait_quiet(20000);

    drv_en = 1'b0;
    @(posedge clk);
    #1;
    rs = "int abc;";
    req_data[15:8] = rs[0];
    req_valid = 2'b10;
    k = 0;
    to = 0;
    while (k < 3 && to < 30) begin
      @(negedge clk);
      if (req_ready[1]) k++;
      @(posedge clk);
      #1;
      to++;
      if (k < 3) req_data[15:8] = rs[k];
    end
    chk("rst_test_progress", k, 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    nres = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid != 0) nres++;
    end
    chk("no_res_after_reset", nres, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
